// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite commit controller: FSM encoding, sprite-count
// limit and the layout of the shadow-register address {sprite, sel}.
package sprite_pkg;

    localparam int MAX_NSPR     = 8;
    localparam int SPR_W        = $clog2(MAX_NSPR);
    localparam int ADDR_W       = 4;
    localparam int ADDR_SEL_BIT = 0;
    localparam int ADDR_SPR_LSB = 1;
    localparam int ADDR_SPR_MSB = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // sel=1 addresses the Y register of a sprite, sel=0 the X register
    function automatic logic addr_is_y(input logic [ADDR_W-1:0] a);
        return a[ADDR_SEL_BIT];
    endfunction

    function automatic logic [SPR_W-1:0] addr_sprite(input logic [ADDR_W-1:0] a);
        return a[ADDR_SPR_MSB:ADDR_SPR_LSB];
    endfunction

endpackage

// File: rtl/sprite_commit_ctrl_if.sv
// CPU-side shadow/commit strobes and sprite load-port bundle for sprite_commit_ctrl.
interface sprite_commit_ctrl_if
    import sprite_pkg::*;
#(
    parameter int NSPR = 4,
    parameter int DW   = 16
);

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DW-1:0]         wr_data;
    logic                  commit_req;
    logic                  frame_start;
    logic [DW-1:0]         ld_data;
    logic [NSPR-1:0]       ld_x_en;
    logic [NSPR-1:0]       ld_y_en;
    logic                  pend;
    logic                  busy;
    logic [2*NSPR-1:0]     dirty;

    modport master (
        output wr_en, wr_addr, wr_data, commit_req, frame_start,
        input  ld_data, ld_x_en, ld_y_en, pend, busy, dirty
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit_req, frame_start,
        output ld_data, ld_x_en, ld_y_en, pend, busy, dirty
    );

endinterface

// File: rtl/sprite_commit_ctrl.sv
// Shadowed sprite X/Y registers committed atomically to the sprite load port at a frame boundary.
// Optional build macro SPRITE_AUTOCOMMIT_EN: frame_start in IDLE commits pending dirty shadows.
module sprite_commit_ctrl
    import sprite_pkg::*;
#(
    parameter int NSPR = 4,
    parameter int DW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sprite_commit_ctrl_if.slave  bus
);

    localparam int NSH = 2 * NSPR;
    localparam int IW  = $clog2(NSH);
    localparam logic [IW-1:0] IDX_LAST = IW'(NSH - 1);

    state_e            state_r;
    state_e            state_next_s;
    logic [IW-1:0]     idx_r;
    logic [IW-1:0]     idx_next_s;
    logic              rearm_r;
    logic              rearm_next_s;
    logic              pend_r;
    logic              busy_r;
    logic [DW-1:0]     shadow_r [NSH];
    logic [NSH-1:0]    dirty_r;

    logic              wr_hit_s;
    logic [IW-1:0]     wr_idx_s;
    logic              ld_hit_s;
    logic [ADDR_W-1:0] idx_ext_s;
    logic [DW-1:0]     ld_data_s;
    logic [NSPR-1:0]   ld_x_en_s;
    logic [NSPR-1:0]   ld_y_en_s;

    // Out-of-range shadow addresses are dropped entirely
    assign wr_hit_s  = bus.wr_en && ({1'b0, bus.wr_addr} < 5'(NSH));
    assign wr_idx_s  = bus.wr_addr[IW-1:0];
    assign ld_hit_s  = (state_r == ST_COMMIT) && dirty_r[idx_r];
    assign idx_ext_s = ADDR_W'(idx_r);

    // Next-state, scan index and re-arm flag
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        rearm_next_s = rearm_r;
        case (state_r)
            ST_IDLE: begin
                idx_next_s   = {IW{1'b0}};
                rearm_next_s = 1'b0;
                if (bus.commit_req) begin
                    state_next_s = ST_ARMED;
                end
`ifdef SPRITE_AUTOCOMMIT_EN
                else if (bus.frame_start && (|dirty_r)) begin
                    state_next_s = ST_COMMIT;
                end
`endif
                else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                idx_next_s   = {IW{1'b0}};
                rearm_next_s = 1'b0;
                if (bus.frame_start) begin
                    state_next_s = ST_COMMIT;
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            ST_COMMIT: begin
                // A request arriving on the final scan cycle still re-arms
                if (idx_r == IDX_LAST) begin
                    idx_next_s   = {IW{1'b0}};
                    rearm_next_s = 1'b0;
                    if (rearm_r || bus.commit_req) begin
                        state_next_s = ST_ARMED;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    idx_next_s   = idx_r + IW'(1);
                    rearm_next_s = rearm_r | bus.commit_req;
                    state_next_s = ST_COMMIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                idx_next_s   = {IW{1'b0}};
                rearm_next_s = 1'b0;
            end
        endcase
    end

    // FSM state, scan index and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {IW{1'b0}};
            rearm_r <= 1'b0;
            pend_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            rearm_r <= rearm_next_s;
            pend_r  <= (state_next_s == ST_ARMED);
            busy_r  <= (state_next_s == ST_COMMIT);
        end
    end

    // Shadow file and dirty flags; a CPU write wins over the scan clearing the same entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSH; i++) begin
                shadow_r[i] <= {DW{1'b0}};
            end
            dirty_r <= {NSH{1'b0}};
        end else begin
            for (int i = 0; i < NSH; i++) begin
                if (wr_hit_s && (wr_idx_s == IW'(i))) begin
                    shadow_r[i] <= bus.wr_data;
                    dirty_r[i]  <= 1'b1;
                end else if (ld_hit_s && (idx_r == IW'(i))) begin
                    dirty_r[i]  <= 1'b0;
                end
            end
        end
    end

    // Load-port decode from the registered scan position
    always_comb begin
        ld_data_s = {DW{1'b0}};
        ld_x_en_s = {NSPR{1'b0}};
        ld_y_en_s = {NSPR{1'b0}};
        if (ld_hit_s) begin
            ld_data_s = shadow_r[idx_r];
            for (int i = 0; i < NSPR; i++) begin
                if (addr_sprite(idx_ext_s) == SPR_W'(i)) begin
                    ld_x_en_s[i] = ~addr_is_y(idx_ext_s);
                    ld_y_en_s[i] = addr_is_y(idx_ext_s);
                end else begin
                    ld_x_en_s[i] = 1'b0;
                    ld_y_en_s[i] = 1'b0;
                end
            end
        end else begin
            ld_data_s = {DW{1'b0}};
            ld_x_en_s = {NSPR{1'b0}};
            ld_y_en_s = {NSPR{1'b0}};
        end
    end

    assign bus.ld_data = ld_data_s;
    assign bus.ld_x_en = ld_x_en_s;
    assign bus.ld_y_en = ld_y_en_s;
    assign bus.pend    = pend_r;
    assign bus.busy    = busy_r;
    assign bus.dirty   = dirty_r;

endmodule

// File: tb/tb_sprite_commit_ctrl.sv
// Directed self-checking bench for sprite_commit_ctrl (NSPR=4, DW=16); SPRITE_AUTOCOMMIT_EN selects the auto-commit case.
module tb_sprite_commit_ctrl;

    localparam int NSPR = 4;
    localparam int DW   = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sprite_commit_ctrl_if #(.NSPR(NSPR), .DW(DW)) bus ();

    sprite_commit_ctrl #(.NSPR(NSPR), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0]  exp_x [8];
    logic [3:0]  exp_y [8];
    logic [15:0] exp_d [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse(input logic cr, input logic fs);
        bus.commit_req  = cr;
        bus.frame_start = fs;
        step();
        bus.commit_req  = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic clr_exp();
        for (int k = 0; k < 8; k++) begin
            exp_x[k] = 4'd0;
            exp_y[k] = 4'd0;
            exp_d[k] = 16'd0;
        end
    endtask

    // Walks the 8 scan cycles, checking the load port and optionally injecting strobes
    task automatic scan(input string nm, input int wr_k, input logic [3:0] wa, input logic [15:0] wd,
                        input int cr_k, input int fs_k);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_busy%0d", nm, k), 32'(bus.busy), 32'd1);
            check($sformatf("%s_pend%0d", nm, k), 32'(bus.pend), 32'd0);
            check($sformatf("%s_x%0d", nm, k), 32'(bus.ld_x_en), 32'(exp_x[k]));
            check($sformatf("%s_y%0d", nm, k), 32'(bus.ld_y_en), 32'(exp_y[k]));
            check($sformatf("%s_d%0d", nm, k), 32'(bus.ld_data), 32'(exp_d[k]));
            if (k == wr_k) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = wa;
                bus.wr_data = wd;
            end
            if (k == cr_k) bus.commit_req = 1'b1;
            if (k == fs_k) bus.frame_start = 1'b1;
            step();
            bus.wr_en       = 1'b0;
            bus.commit_req  = 1'b0;
            bus.frame_start = 1'b0;
        end
    endtask

    initial begin
        int n;
        rst             = 1'b1;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = 4'd0;
        bus.wr_data     = 16'd0;
        bus.commit_req  = 1'b0;
        bus.frame_start = 1'b0;
        #12;
        check("rst_pend",  32'(bus.pend),    32'd0);
        check("rst_busy",  32'(bus.busy),    32'd0);
        check("rst_dirty", 32'(bus.dirty),   32'd0);
        check("rst_x",     32'(bus.ld_x_en), 32'd0);
        check("rst_y",     32'(bus.ld_y_en), 32'd0);
        check("rst_d",     32'(bus.ld_data), 32'd0);
        rst = 1'b0;
        step();

        // Basic commit of X0 and Y1
        wr(4'd0, 16'd100);
        wr(4'd3, 16'd200);
        check("A_dirty", 32'(bus.dirty), 32'h09);
        pulse(1'b1, 1'b0);
        check("A_pend", 32'(bus.pend), 32'd1);
        check("A_busy", 32'(bus.busy), 32'd0);
        pulse(1'b0, 1'b1);
        clr_exp();
        exp_x[0] = 4'b0001; exp_d[0] = 16'd100;
        exp_y[3] = 4'b0010; exp_d[3] = 16'd200;
        scan("A", -1, 4'd0, 16'd0, -1, -1);
        check("A_end_busy",  32'(bus.busy),  32'd0);
        check("A_end_pend",  32'(bus.pend),  32'd0);
        check("A_end_dirty", 32'(bus.dirty), 32'd0);

        // Armed without frame_start holds for 1000 cycles
        pulse(1'b1, 1'b0);
        n = 0;
        for (int c = 0; c < 1000; c++) begin
            if (bus.pend === 1'b1 && bus.busy === 1'b0 && bus.ld_x_en === 4'd0 && bus.ld_y_en === 4'd0)
                n++;
            step();
        end
        check("B_hold", 32'(n), 32'd1000);
        pulse(1'b1, 1'b0);
        check("B_cr_armed_pend", 32'(bus.pend), 32'd1);
        check("B_cr_armed_busy", 32'(bus.busy), 32'd0);
        pulse(1'b0, 1'b1);
        clr_exp();
        scan("B", -1, 4'd0, 16'd0, -1, -1);
        check("B_end_busy", 32'(bus.busy), 32'd0);
        check("B_end_pend", 32'(bus.pend), 32'd0);

        // Out-of-range addresses are ignored
        wr(4'd9, 16'h0555);
        wr(4'd15, 16'h0aaa);
        check("G_dirty", 32'(bus.dirty), 32'd0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        clr_exp();
        scan("G", -1, 4'd0, 16'd0, -1, -1);

        // Write to the entry being scanned
        wr(4'd2, 16'd7);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        clr_exp();
        exp_x[2] = 4'b0010; exp_d[2] = 16'd7;
        scan("C1", 2, 4'd2, 16'd5, -1, -1);
        check("C_dirty", 32'(bus.dirty), 32'h04);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        clr_exp();
        exp_x[2] = 4'b0010; exp_d[2] = 16'd5;
        scan("C2", -1, 4'd0, 16'd0, -1, -1);
        check("C_end_dirty", 32'(bus.dirty), 32'd0);

        // Re-arm during COMMIT; frame_start during COMMIT ignored
        wr(4'd5, 16'd33);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        clr_exp();
        exp_y[5] = 4'b0100; exp_d[5] = 16'd33;
        scan("D1", -1, 4'd0, 16'd0, 1, -1);
        check("D_rearm_pend", 32'(bus.pend),  32'd1);
        check("D_rearm_busy", 32'(bus.busy),  32'd0);
        check("D_dirty",      32'(bus.dirty), 32'd0);
        pulse(1'b0, 1'b1);
        clr_exp();
        scan("D2", -1, 4'd0, 16'd0, -1, 3);
        check("D_end_busy", 32'(bus.busy), 32'd0);
        check("D_end_pend", 32'(bus.pend), 32'd0);

        // Reset in the middle of a scan
        wr(4'd3, 16'd77);
        wr(4'd6, 16'd88);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        step();
        step();
        step();
        check("E_y3", 32'(bus.ld_y_en), 32'b0010);
        check("E_d3", 32'(bus.ld_data), 32'd77);
        rst = 1'b1;
        #1;
        check("E_rst_x",     32'(bus.ld_x_en), 32'd0);
        check("E_rst_y",     32'(bus.ld_y_en), 32'd0);
        check("E_rst_d",     32'(bus.ld_data), 32'd0);
        check("E_rst_busy",  32'(bus.busy),    32'd0);
        check("E_rst_pend",  32'(bus.pend),    32'd0);
        check("E_rst_dirty", 32'(bus.dirty),   32'd0);
        #2;
        rst = 1'b0;
        step();
        step();
        check("E_after_busy", 32'(bus.busy),    32'd0);
        check("E_after_x",    32'(bus.ld_x_en), 32'd0);

        // frame_start in IDLE, then simultaneous commit_req/frame_start
        wr(4'd1, 16'd42);
        pulse(1'b0, 1'b1);
`ifdef SPRITE_AUTOCOMMIT_EN
        clr_exp();
        exp_y[1] = 4'b0001; exp_d[1] = 16'd42;
        scan("AUTO", -1, 4'd0, 16'd0, -1, -1);
        check("AUTO_dirty", 32'(bus.dirty), 32'd0);
`else
        check("F_idle_busy",  32'(bus.busy),  32'd0);
        check("F_idle_pend",  32'(bus.pend),  32'd0);
        check("F_idle_dirty", 32'(bus.dirty), 32'h02);
`endif
        wr(4'd1, 16'd43);
        pulse(1'b1, 1'b1);
        check("F_both_pend", 32'(bus.pend), 32'd1);
        check("F_both_busy", 32'(bus.busy), 32'd0);
        pulse(1'b0, 1'b1);
        clr_exp();
        exp_y[1] = 4'b0001; exp_d[1] = 16'd43;
        scan("F", -1, 4'd0, 16'd0, -1, -1);
        check("F_end_dirty", 32'(bus.dirty), 32'd0);
        check("F_end_busy",  32'(bus.busy),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
